tmr_vote_monitor: RTL and testbench
===================================

Name: tmr_vote_monitor

Overview:
- Downstream consumer of a triplicated 8-bit register stage, e.g. the accumulator register after TMR expansion into copies A/B/C.
- Takes the three copies and produces a bitwise-majority voted word, registered with a valid strobe.
- Counts per-lane disagreements in saturating counters.
- Runs a fault-classification FSM that decides whether one lane is persistently faulty or whether the redundancy is broken.

Parameters:
- W, 8, data width of each copy and of the voted output.
- CW, 8, width of each per-lane saturating error counter.
- FAULT_THR, 4, consecutive valid cycles with the same single lane mismatching before the FSM declares FAULT; legal range 2..15.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low (asserted when 0).
- in_valid  in  1  qualifies inA/inB/inC this cycle.
- inA  in  W  copy A.
- inB  in  W  copy B.
- inC  in  W  copy C.
- clr_err  in  1  synchronous clear of counters and FSM.
- out_voted  out  W  registered bitwise-majority word.
- out_valid  out  1  registered in_valid.
- err_lanes  out  3  registered per-cycle mismatch flags {C,B,A}.
- err_cnt_a  out  CW  saturating mismatch count, lane A.
- err_cnt_b  out  CW  saturating mismatch count, lane B.
- err_cnt_c  out  CW  saturating mismatch count, lane C.
- state  out  2  FSM state: 0 OK, 1 SUSPECT, 2 FAULT, 3 MULTI.
- fault_lane  out  2  0 none, 1 A, 2 B, 3 C; nonzero only in FAULT.

Behaviour:
- Reset (rst==0 at posedge) sets all outputs to 0, state=OK, internal streak=0, suspect lane=none. Reset overrides clr_err and in_valid.
- Vote: v = (A&B)|(B&C)|(A&C), bitwise.
- Lane mismatch flags: mA = (inA!=v), mB = (inB!=v), mC = (inC!=v). nmis = mA+mB+mC, range 0..3; more than one lane can differ when the faults sit on different bits.
- Latency is 1 cycle, on valid cycles:
  - out_voted <= v.
  - err_lanes <= {mC,mB,mA}.
  - out_valid <= 1.
- On invalid cycles:
  - out_valid <= 0.
  - out_voted holds its value.
  - err_lanes <= 0.
  - Counters and FSM are unchanged.
- Counters: on each valid cycle, each mismatching lane's counter increments by 1 and saturates at 2^CW-1; it never wraps.
- clr_err=1 (rst high):
  - Counters, streak and suspect lane clear to 0; state goes to OK; fault_lane goes to 0.
  - clr_err has priority over a same-cycle mismatch, so that mismatch is not counted and not classified.
  - The voted data path and err_lanes still update normally.
- FSM transitions apply on valid cycles only, with clr_err=0:
  - OK:
    - nmis=0 stays OK.
    - nmis=1 goes to SUSPECT, suspect=lane, streak=1.
    - nmis>=2 goes to MULTI.
  - SUSPECT:
    - nmis=0 goes to OK, streak=0.
    - nmis=1 on the same lane: streak+1. When the new streak equals FAULT_THR, go to FAULT with fault_lane=suspect.
    - nmis=1 on a different lane: stay SUSPECT, suspect=new lane, streak=1.
    - nmis>=2 goes to MULTI.
  - FAULT is sticky:
    - nmis=0, or nmis=1 on the faulty lane, stays FAULT.
    - Any mismatch on another lane goes to MULTI.
  - MULTI is sticky until clr_err or reset.
- fault_lane is registered alongside state, and forced to 0 in every state other than FAULT.
- Invalid cycles never break a streak.

Test Plan:
- Reset, then in_valid=1 with A=B=C=8'h5A: 1 cycle later out_voted=8'h5A, out_valid=1, err_lanes=0, state=OK, all counters 0.
- A=8'hFF, B=C=8'h0F for 4 consecutive valid cycles (FAULT_THR=4):
  - out_voted=8'h0F each cycle; err_lanes=3'b001.
  - state goes SUSPECT, SUSPECT, SUSPECT, FAULT after the 4th cycle.
  - fault_lane=1; err_cnt_a=4.
- A lane-B glitch for 2 cycles, 1 clean valid cycle, then 2 more B mismatches: state returns to OK on the clean cycle, never reaches FAULT; err_cnt_b=4.
- Multi-lane fault: A=8'h01, B=8'h02, C=8'h00:
  - v=8'h00, mA=mB=1; state=MULTI, err_cnt_a=err_cnt_b=1.
  - A following clean cycle leaves state at MULTI.
  - clr_err=1 then gives state=OK and counters=0.
- Saturation and clr_err precedence, with CW=2:
  - Drive 5 lane-C mismatches; err_cnt_c stops at 3.
  - Assert clr_err together with a lane-C mismatch: err_cnt_c=0, state=OK, err_lanes=3'b100.
- Interleave in_valid=0 between SUSPECT mismatches: streak preserved, FAULT reached after the 4th valid mismatch. Assert rst=0 mid-streak: all outputs 0, state=OK on the next cycle.

Source files
------------

// File: rtl/tmr_vote_monitor.sv
// tmr_vote_monitor
//   Consumer of a triplicated W-bit register stage (copies A/B/C). Produces a
//   registered bitwise-majority word, per-lane mismatch flags, per-lane
//   saturating mismatch counters and a fault-classification FSM that decides
//   whether a single lane is persistently faulty or redundancy is lost.
//
// Handshake: in_valid qualifies inA/inB/inC in the cycle it is high; there is
//   no backpressure. out_valid is in_valid delayed by one cycle and qualifies
//   out_voted/err_lanes in that same cycle.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   in_valid            input qualifier
//   inA, inB, inC       the three copies
//   clr_err             synchronous clear of counters and classification FSM
//   out_voted           registered majority word (holds on invalid cycles)
//   out_valid           registered in_valid
//   err_lanes           registered {C,B,A} mismatch flags (0 on invalid cycles)
//   err_cnt_a/b/c       saturating per-lane mismatch counters
//   state               FSM state: 0 OK, 1 SUSPECT, 2 FAULT, 3 MULTI
//   fault_lane          0 none, 1 A, 2 B, 3 C; nonzero only in FAULT
module tmr_vote_monitor #(
  parameter int W         = 8,
  parameter int CW        = 8,
  parameter int FAULT_THR = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-1:0]  inA,
  input  logic [W-1:0]  inB,
  input  logic [W-1:0]  inC,
  input  logic          clr_err,
  output logic [W-1:0]  out_voted,
  output logic          out_valid,
  output logic [2:0]    err_lanes,
  output logic [CW-1:0] err_cnt_a,
  output logic [CW-1:0] err_cnt_b,
  output logic [CW-1:0] err_cnt_c,
  output logic [1:0]    state,
  output logic [1:0]    fault_lane
);

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2,
    ST_MULTI   = 2'd3
  } state_t;

  localparam logic [3:0] THR = 4'(FAULT_THR);

  // ---------------------------------------------------------------- vote
  logic [W-1:0] voted;
  logic [2:0]   mis;       // {C,B,A}
  logic [1:0]   nmis;
  logic [1:0]   mis_lane;  // lane code of the single mismatching lane

  assign voted = (inA & inB) | (inB & inC) | (inA & inC);
  assign mis   = {(inC != voted), (inB != voted), (inA != voted)};
  assign nmis  = {1'b0, mis[0]} + {1'b0, mis[1]} + {1'b0, mis[2]};

  // Only meaningful when nmis == 1.
  always_comb begin
    mis_lane = 2'd0;
    if (mis[0])      mis_lane = 2'd1;
    else if (mis[1]) mis_lane = 2'd2;
    else if (mis[2]) mis_lane = 2'd3;
  end

  // ---------------------------------------------------------------- FSM
  state_t     state_q, state_d;
  logic [1:0] suspect_q, suspect_d;   // also holds the faulty lane in FAULT
  logic [3:0] streak_q, streak_d;
  logic [3:0] streak_inc;
  logic [1:0] fault_lane_d;

  assign streak_inc = streak_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    suspect_d    = suspect_q;
    streak_d     = streak_q;
    if (clr_err) begin
      state_d   = ST_OK;
      suspect_d = 2'd0;
      streak_d  = 4'd0;
    end else if (in_valid) begin
      // Invalid cycles fall through untouched, so they never break a streak.
      case (state_q)
        ST_OK: begin
          if (nmis == 2'd1) begin
            state_d   = ST_SUSPECT;
            suspect_d = mis_lane;
            streak_d  = 4'd1;
          end else if (nmis >= 2'd2) begin
            state_d = ST_MULTI;
          end
        end
        ST_SUSPECT: begin
          if (nmis == 2'd0) begin
            state_d   = ST_OK;
            suspect_d = 2'd0;
            streak_d  = 4'd0;
          end else if (nmis == 2'd1) begin
            if (mis_lane == suspect_q) begin
              streak_d = streak_inc;
              if (streak_inc == THR) state_d = ST_FAULT;
            end else begin
              // A different single lane restarts the streak on that lane.
              suspect_d = mis_lane;
              streak_d  = 4'd1;
            end
          end else begin
            state_d = ST_MULTI;
          end
        end
        ST_FAULT: begin
          // Sticky: only a mismatch on some other lane escalates.
          if (nmis >= 2'd2 || (nmis == 2'd1 && mis_lane != suspect_q))
            state_d = ST_MULTI;
        end
        ST_MULTI: state_d = ST_MULTI;
        default:  state_d = ST_OK;
      endcase
    end
    fault_lane_d = (state_d == ST_FAULT) ? suspect_d : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_OK;
      suspect_q  <= 2'd0;
      streak_q   <= 4'd0;
      fault_lane <= 2'd0;
    end else begin
      state_q    <= state_d;
      suspect_q  <= suspect_d;
      streak_q   <= streak_d;
      fault_lane <= fault_lane_d;
    end
  end

  assign state = state_q;

  // ---------------------------------------------------------------- data path
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_voted <= '0;
      out_valid <= 1'b0;
      err_lanes <= 3'd0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_voted <= voted;
        err_lanes <= mis;
      end else begin
        err_lanes <= 3'd0;
      end
    end
  end

  // ---------------------------------------------------------------- counters
  // Saturating: once all ones, further mismatches are dropped.
  always_ff @(posedge clk) begin
    if (!rst || clr_err) begin
      err_cnt_a <= '0;
      err_cnt_b <= '0;
      err_cnt_c <= '0;
    end else if (in_valid) begin
      if (mis[0] && err_cnt_a != '1) err_cnt_a <= err_cnt_a + CW'(1);
      if (mis[1] && err_cnt_b != '1) err_cnt_b <= err_cnt_b + CW'(1);
      if (mis[2] && err_cnt_c != '1) err_cnt_c <= err_cnt_c + CW'(1);
    end
  end

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Bench for tmr_vote_monitor: table of {inputs, expected outputs} rows applied
// one per clock; expected records go into a scoreboard queue when a row is
// driven and are popped and compared one cycle later. A second instance with
// CW=2 shares the inputs to exercise counter saturation.
module tb_tmr_vote_monitor;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_a, in_b, in_c;
  logic       clr_err;

  logic [7:0] out_voted;
  logic       out_valid;
  logic [2:0] err_lanes;
  logic [7:0] err_cnt_a, err_cnt_b, err_cnt_c;
  logic [1:0] state, fault_lane;

  logic [7:0] out_voted2;
  logic       out_valid2;
  logic [2:0] err_lanes2;
  logic [1:0] cnt_a2, cnt_b2, cnt_c2;
  logic [1:0] state2, fault_lane2;

  tmr_vote_monitor #(.W(8), .CW(8), .FAULT_THR(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .inA(in_a), .inB(in_b), .inC(in_c), .clr_err(clr_err),
    .out_voted(out_voted), .out_valid(out_valid), .err_lanes(err_lanes),
    .err_cnt_a(err_cnt_a), .err_cnt_b(err_cnt_b), .err_cnt_c(err_cnt_c),
    .state(state), .fault_lane(fault_lane)
  );

  tmr_vote_monitor #(.W(8), .CW(2), .FAULT_THR(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .inA(in_a), .inB(in_b), .inC(in_c), .clr_err(clr_err),
    .out_voted(out_voted2), .out_valid(out_valid2), .err_lanes(err_lanes2),
    .err_cnt_a(cnt_a2), .err_cnt_b(cnt_b2), .err_cnt_c(cnt_c2),
    .state(state2), .fault_lane(fault_lane2)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- table
  typedef struct {
    logic       rst_n;
    logic       vld;
    logic [7:0] a, b, c;
    logic       clr;
    logic [7:0] e_voted;
    logic       e_valid;
    logic [2:0] e_lanes;
    logic [1:0] e_state;
    logic [1:0] e_fl;
    logic [7:0] e_ca, e_cb, e_cc;
  } vec_t;

  typedef struct packed {
    logic [7:0] voted;
    logic       valid;
    logic [2:0] lanes;
    logic [1:0] st;
    logic [1:0] fl;
    logic [7:0] ca, cb, cc;
  } exp_t;

  vec_t vec_q[$];
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int row,
                       input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL row %0d %s: got %0h expected %0h", row, name, act, req);
    end
  endtask

  function automatic logic [7:0] sat3(input logic [7:0] v);
    return (v > 8'd3) ? 8'd3 : v;
  endfunction

  // ---------------------------------------------------------------- driver
  task automatic drive(input vec_t v);
    exp_t e;
    rst      = v.rst_n;
    in_valid = v.vld;
    in_a     = v.a;
    in_b     = v.b;
    in_c     = v.c;
    clr_err  = v.clr;
    e = '{voted: v.e_voted, valid: v.e_valid, lanes: v.e_lanes, st: v.e_state,
          fl: v.e_fl, ca: v.e_ca, cb: v.e_cb, cc: v.e_cc};
    exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------- scoreboard
  task automatic compare_row(input int row);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL row %0d scoreboard: got empty queue expected one entry", row);
      return;
    end
    total--;
    e = exp_q.pop_front();
    check("out_voted",  row, out_voted,         e.voted);
    check("out_valid",  row, {7'd0, out_valid}, {7'd0, e.valid});
    check("err_lanes",  row, {5'd0, err_lanes}, {5'd0, e.lanes});
    check("state",      row, {6'd0, state},     {6'd0, e.st});
    check("fault_lane", row, {6'd0, fault_lane},{6'd0, e.fl});
    check("err_cnt_a",  row, err_cnt_a,         e.ca);
    check("err_cnt_b",  row, err_cnt_b,         e.cb);
    check("err_cnt_c",  row, err_cnt_c,         e.cc);
    check("cw2_state",  row, {6'd0, state2},    {6'd0, e.st});
    check("cw2_cnt_a",  row, {6'd0, cnt_a2},    sat3(e.ca));
    check("cw2_cnt_b",  row, {6'd0, cnt_b2},    sat3(e.cb));
    check("cw2_cnt_c",  row, {6'd0, cnt_c2},    sat3(e.cc));
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0; clr_err = 1'b0;

    // rst vld  a      b      c     clr  voted v  lanes  st fl  ca     cb     cc
    // reset
    vec_q.push_back('{0,1'b0,8'h00,8'h00,8'h00,1'b0, 8'h00,1'b0,3'b000,2'd0,2'd0,8'd0,8'd0,8'd0});
    vec_q.push_back('{0,1'b1,8'h12,8'h34,8'h56,1'b1, 8'h00,1'b0,3'b000,2'd0,2'd0,8'd0,8'd0,8'd0});
    // all agree
    vec_q.push_back('{1,1'b1,8'h5A,8'h5A,8'h5A,1'b0, 8'h5A,1'b1,3'b000,2'd0,2'd0,8'd0,8'd0,8'd0});
    // lane A stuck: SUSPECT x3 then FAULT
    vec_q.push_back('{1,1'b1,8'hFF,8'h0F,8'h0F,1'b0, 8'h0F,1'b1,3'b001,2'd1,2'd0,8'd1,8'd0,8'd0});
    vec_q.push_back('{1,1'b1,8'hFF,8'h0F,8'h0F,1'b0, 8'h0F,1'b1,3'b001,2'd1,2'd0,8'd2,8'd0,8'd0});
    vec_q.push_back('{1,1'b1,8'hFF,8'h0F,8'h0F,1'b0, 8'h0F,1'b1,3'b001,2'd1,2'd0,8'd3,8'd0,8'd0});
    vec_q.push_back('{1,1'b1,8'hFF,8'h0F,8'h0F,1'b0, 8'h0F,1'b1,3'b001,2'd2,2'd1,8'd4,8'd0,8'd0});
    // FAULT sticky under clean and same-lane cycles
    vec_q.push_back('{1,1'b1,8'h0F,8'h0F,8'h0F,1'b0, 8'h0F,1'b1,3'b000,2'd2,2'd1,8'd4,8'd0,8'd0});
    vec_q.push_back('{1,1'b1,8'hFF,8'h0F,8'h0F,1'b0, 8'h0F,1'b1,3'b001,2'd2,2'd1,8'd5,8'd0,8'd0});
    vec_q.push_back('{1,1'b1,8'h33,8'h33,8'h33,1'b1, 8'h33,1'b1,3'b000,2'd0,2'd0,8'd0,8'd0,8'd0});
    // lane B glitch x2, clean, x2: back to OK, no FAULT
    vec_q.push_back('{1,1'b1,8'h00,8'h10,8'h00,1'b0, 8'h00,1'b1,3'b010,2'd1,2'd0,8'd0,8'd1,8'd0});
    vec_q.push_back('{1,1'b1,8'h00,8'h10,8'h00,1'b0, 8'h00,1'b1,3'b010,2'd1,2'd0,8'd0,8'd2,8'd0});
    vec_q.push_back('{1,1'b1,8'h00,8'h00,8'h00,1'b0, 8'h00,1'b1,3'b000,2'd0,2'd0,8'd0,8'd2,8'd0});
    vec_q.push_back('{1,1'b1,8'h00,8'h10,8'h00,1'b0, 8'h00,1'b1,3'b010,2'd1,2'd0,8'd0,8'd3,8'd0});
    vec_q.push_back('{1,1'b1,8'h00,8'h10,8'h00,1'b0, 8'h00,1'b1,3'b010,2'd1,2'd0,8'd0,8'd4,8'd0});
    // invalid cycles interleaved: streak survives, FAULT at 4th valid mismatch
    vec_q.push_back('{1,1'b0,8'hFF,8'h00,8'hAA,1'b0, 8'h00,1'b0,3'b000,2'd1,2'd0,8'd0,8'd4,8'd0});
    vec_q.push_back('{1,1'b1,8'h00,8'h10,8'h00,1'b0, 8'h00,1'b1,3'b010,2'd1,2'd0,8'd0,8'd5,8'd0});
    vec_q.push_back('{1,1'b0,8'hFF,8'h00,8'hAA,1'b0, 8'h00,1'b0,3'b000,2'd1,2'd0,8'd0,8'd5,8'd0});
    vec_q.push_back('{1,1'b1,8'h00,8'h10,8'h00,1'b0, 8'h00,1'b1,3'b010,2'd2,2'd2,8'd0,8'd6,8'd0});
    // other lane while in FAULT -> MULTI
    vec_q.push_back('{1,1'b1,8'h01,8'h00,8'h00,1'b0, 8'h00,1'b1,3'b001,2'd3,2'd0,8'd1,8'd6,8'd0});
    vec_q.push_back('{1,1'b1,8'h00,8'h00,8'h00,1'b1, 8'h00,1'b1,3'b000,2'd0,2'd0,8'd0,8'd0,8'd0});
    // two lanes on different bits -> MULTI, sticky, cleared by clr_err
    vec_q.push_back('{1,1'b1,8'h01,8'h02,8'h00,1'b0, 8'h00,1'b1,3'b011,2'd3,2'd0,8'd1,8'd1,8'd0});
    vec_q.push_back('{1,1'b1,8'h77,8'h77,8'h77,1'b0, 8'h77,1'b1,3'b000,2'd3,2'd0,8'd1,8'd1,8'd0});
    vec_q.push_back('{1,1'b1,8'h77,8'h77,8'h77,1'b1, 8'h77,1'b1,3'b000,2'd0,2'd0,8'd0,8'd0,8'd0});
    // suspect lane switch restarts the streak
    vec_q.push_back('{1,1'b1,8'h00,8'h00,8'h80,1'b0, 8'h00,1'b1,3'b100,2'd1,2'd0,8'd0,8'd0,8'd1});
    vec_q.push_back('{1,1'b1,8'h04,8'h00,8'h00,1'b0, 8'h00,1'b1,3'b001,2'd1,2'd0,8'd1,8'd0,8'd1});
    vec_q.push_back('{1,1'b1,8'h04,8'h00,8'h00,1'b0, 8'h00,1'b1,3'b001,2'd1,2'd0,8'd2,8'd0,8'd1});
    vec_q.push_back('{1,1'b1,8'h04,8'h00,8'h00,1'b0, 8'h00,1'b1,3'b001,2'd1,2'd0,8'd3,8'd0,8'd1});
    vec_q.push_back('{1,1'b1,8'h04,8'h00,8'h00,1'b0, 8'h00,1'b1,3'b001,2'd2,2'd1,8'd4,8'd0,8'd1});
    vec_q.push_back('{1,1'b1,8'h00,8'h00,8'h00,1'b1, 8'h00,1'b1,3'b000,2'd0,2'd0,8'd0,8'd0,8'd0});
    // lane C x5: CW=2 instance saturates at 3, then clr_err beats a mismatch
    vec_q.push_back('{1,1'b1,8'h3C,8'h3C,8'h00,1'b0, 8'h3C,1'b1,3'b100,2'd1,2'd0,8'd0,8'd0,8'd1});
    vec_q.push_back('{1,1'b1,8'h3C,8'h3C,8'h00,1'b0, 8'h3C,1'b1,3'b100,2'd1,2'd0,8'd0,8'd0,8'd2});
    vec_q.push_back('{1,1'b1,8'h3C,8'h3C,8'h00,1'b0, 8'h3C,1'b1,3'b100,2'd1,2'd0,8'd0,8'd0,8'd3});
    vec_q.push_back('{1,1'b1,8'h3C,8'h3C,8'h00,1'b0, 8'h3C,1'b1,3'b100,2'd2,2'd3,8'd0,8'd0,8'd4});
    vec_q.push_back('{1,1'b1,8'h3C,8'h3C,8'h00,1'b0, 8'h3C,1'b1,3'b100,2'd2,2'd3,8'd0,8'd0,8'd5});
    vec_q.push_back('{1,1'b1,8'h3C,8'h3C,8'h00,1'b1, 8'h3C,1'b1,3'b100,2'd0,2'd0,8'd0,8'd0,8'd0});
    // all three lanes differ on separate bits -> MULTI from OK
    vec_q.push_back('{1,1'b1,8'h01,8'h02,8'h04,1'b0, 8'h00,1'b1,3'b111,2'd3,2'd0,8'd1,8'd1,8'd1});
    vec_q.push_back('{1,1'b1,8'h00,8'h00,8'h00,1'b1, 8'h00,1'b1,3'b000,2'd0,2'd0,8'd0,8'd0,8'd0});
    // reset mid-streak, then a fresh 4-cycle streak is needed
    vec_q.push_back('{1,1'b1,8'hFF,8'h00,8'h00,1'b0, 8'h00,1'b1,3'b001,2'd1,2'd0,8'd1,8'd0,8'd0});
    vec_q.push_back('{1,1'b1,8'hFF,8'h00,8'h00,1'b0, 8'h00,1'b1,3'b001,2'd1,2'd0,8'd2,8'd0,8'd0});
    vec_q.push_back('{0,1'b1,8'hFF,8'h00,8'h00,1'b0, 8'h00,1'b0,3'b000,2'd0,2'd0,8'd0,8'd0,8'd0});
    vec_q.push_back('{1,1'b1,8'hFF,8'h00,8'h00,1'b0, 8'h00,1'b1,3'b001,2'd1,2'd0,8'd1,8'd0,8'd0});
    vec_q.push_back('{1,1'b1,8'hFF,8'h00,8'h00,1'b0, 8'h00,1'b1,3'b001,2'd1,2'd0,8'd2,8'd0,8'd0});
    vec_q.push_back('{1,1'b1,8'hFF,8'h00,8'h00,1'b0, 8'h00,1'b1,3'b001,2'd1,2'd0,8'd3,8'd0,8'd0});
    vec_q.push_back('{1,1'b1,8'hFF,8'h00,8'h00,1'b0, 8'h00,1'b1,3'b001,2'd2,2'd1,8'd4,8'd0,8'd0});
    // voted word holds across invalid cycles; clr_err works on invalid cycles
    vec_q.push_back('{1,1'b1,8'hAA,8'hAA,8'hAA,1'b0, 8'hAA,1'b1,3'b000,2'd2,2'd1,8'd4,8'd0,8'd0});
    vec_q.push_back('{1,1'b0,8'h55,8'h55,8'h55,1'b0, 8'hAA,1'b0,3'b000,2'd2,2'd1,8'd4,8'd0,8'd0});
    vec_q.push_back('{1,1'b0,8'h55,8'h55,8'h55,1'b1, 8'hAA,1'b0,3'b000,2'd0,2'd0,8'd0,8'd0,8'd0});

    for (int i = 0; i < vec_q.size(); i++) begin
      drive(vec_q[i]);
      @(posedge clk);
      #1;
      compare_row(i);
    end

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
